cd_spi_csr_bridge: RTL and testbench

// - SPI slave (mode 0, MSB first) that converts host SPI transactions into the single-cycle csr_* bus of the CDBUS controller.
// - Sits directly upstream of the CSR block: drives csr_address/csr_read/csr_write/csr_writedata/chip_select and consumes csr_readdata.
// - All SPI signals are oversampled in the clk domain; no SCLK-clocked logic.

---
 rtl/cd_spi_pkg.sv | 16 +
 rtl/cd_sync_bit.sv | 20 ++
 rtl/cd_spi_csr_bridge.sv | 142 ++++++++++++++
 tb/tb_cd_spi_csr_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cd_spi_pkg.sv
// Shared types and command-byte field positions for the SPI-to-CSR bridge.
package cd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam int unsigned CMD_WR_BIT   = 7;
  localparam int unsigned CMD_INC_BIT  = 6;
  localparam int unsigned CMD_ADDR_LSB = 0;
  localparam int unsigned CMD_ADDR_MSB = 4;

endpackage

// File: rtl/cd_sync_bit.sv
// N-stage single-bit synchroniser into the clk domain, clears to 0 on reset.
module cd_sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ff <= '0;
    else          ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/cd_spi_csr_bridge.sv
// Mode-0 SPI slave that turns host frames into single-cycle csr_* accesses.
// Define CD_SPI_ADDR_INC_EN to honour the command inc bit (address auto-increment).
module cd_spi_csr_bridge
  import cd_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_nss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              chip_select,
  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  input  logic [7:0]        csr_readdata,
  output logic              csr_write,
  output logic [7:0]        csr_writedata
);

`ifdef CD_SPI_ADDR_INC_EN
  localparam bit ADDR_INC = 1'b1;
`else
  localparam bit ADDR_INC = 1'b0;
`endif

  logic sclk_s, nss_s, mosi_s;
  logic sclk_d, nss_d;
  logic sclk_rise, sclk_fall, nss_fall;

  cd_sync_bit #(.N(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(spi_sclk), .q(sclk_s));
  cd_sync_bit #(.N(SYNC_STAGES)) u_sync_nss  (.clk(clk), .reset_n(reset_n), .d(spi_nss),  .q(nss_s));
  cd_sync_bit #(.N(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s));

  // nss_d resets low so a select held low across reset never looks like a fresh frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d <= 1'b0;
      nss_d  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      nss_d  <= nss_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign nss_fall  = nss_d & ~nss_s;

  state_t      state, state_nx;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_in, shift_out, rx_byte;
  logic        load_pend, cmd_inc, byte_done;

  assign rx_byte   = {shift_in[6:0], mosi_s};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7) & ~nss_s & (state != IDLE);
  assign spi_miso  = shift_out[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (nss_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (nss_fall) state_nx = CMD;
        CMD:     if (byte_done) state_nx = rx_byte[CMD_WR_BIT] ? WDATA : RDATA;
        default: state_nx = state;
      endcase
    end
  end

  // Bit shifting, strobe generation, read-data load and address tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt       <= 3'd0;
      shift_in      <= 8'd0;
      shift_out     <= 8'd0;
      load_pend     <= 1'b0;
      cmd_inc       <= 1'b0;
      chip_select   <= 1'b0;
      spi_miso_oe   <= 1'b0;
      csr_address   <= '0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_writedata <= 8'd0;
    end else begin
      csr_read    <= 1'b0;
      csr_write   <= 1'b0;
      chip_select <= (state_nx != IDLE);
      spi_miso_oe <= (state_nx != IDLE);

      if (cmd_inc && (csr_read || csr_write))
        csr_address <= csr_address + ADDR_W'(1);

      if (state == IDLE || nss_s) begin
        bit_cnt   <= 3'd0;
        shift_in  <= 8'd0;
        shift_out <= 8'd0;
        load_pend <= 1'b0;
      end else begin
        if (sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= rx_byte;
        end

        if (byte_done) begin
          case (state)
            CMD: begin
              csr_address <= ADDR_W'(rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
              cmd_inc     <= ADDR_INC & rx_byte[CMD_INC_BIT];
              csr_read    <= ~rx_byte[CMD_WR_BIT];
            end
            WDATA: begin
              csr_write     <= 1'b1;
              csr_writedata <= rx_byte;
            end
            RDATA:   csr_read <= 1'b1;
            default: ;
          endcase
        end

        // The fall right after a load is skipped so the fetched MSB is presented first
        if (csr_read) begin
          shift_out <= csr_readdata;
          load_pend <= 1'b1;
        end else if (sclk_fall) begin
          if (load_pend) load_pend <= 1'b0;
          else           shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// Self-checking bench for cd_spi_csr_bridge: directed vector table, random frames, reset/abort corners.
module tb_cd_spi_csr_bridge;

  localparam int unsigned AW = 5;
  localparam int H = 6;
`ifdef CD_SPI_ADDR_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_nss = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, chip_select, csr_read, csr_write;
  logic [AW-1:0] csr_address;
  logic [7:0] csr_readdata, csr_writedata;

  logic [7:0] mem [32];
  logic [7:0] tx [8];
  logic [7:0] rx [8];
  int total = 0;
  int bad = 0;
  int both = 0;

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t got[$];
  ev_t exp_q[$];

  typedef struct {
    logic [4:0][7:0] b;
    int              nd;
    int              xbits;
    int              exp_wr;
    int              exp_rd;
    logic [4:0]      exp_a0;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  assign csr_readdata = mem[csr_address];

  cd_spi_csr_bridge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_sclk     (spi_sclk),
    .spi_nss      (spi_nss),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .chip_select  (chip_select),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata)
  );

  // Bus monitor: one record per clk a strobe is high
  always @(negedge clk) begin
    if (reset_n) begin
      if (csr_read && csr_write) both++;
      if (csr_write)     got.push_back('{1'b1, csr_address, csr_writedata});
      else if (csr_read) got.push_back('{1'b0, csr_address, csr_readdata});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (H) @(posedge clk);
    #1;
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    spi_sclk = 1'b0;
  endtask

  task automatic spi_frame(input string tag, input int nbytes, input int xbits);
    logic m;
    logic [7:0] r;
    got.delete();
    spi_nss = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    check({tag, ".sel"}, 32'({chip_select, spi_miso_oe}), 32'h3);
    for (int i = 0; i < nbytes; i++) begin
      for (int b = 7; b >= 0; b--) begin
        spi_bit(tx[i][b], m);
        r[b] = m;
      end
      rx[i] = r;
    end
    for (int b = 0; b < xbits; b++) spi_bit(tx[nbytes][7-b], m);
    repeat (H) @(posedge clk);
    #1;
    spi_nss = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Address of the k-th access of a frame: base plus k when incrementing is active
  function automatic logic [4:0] acc_addr(input logic [7:0] cmd, input int k);
    int a;
    a = int'(cmd[4:0]) + ((INC_EN && cmd[6]) ? k : 0);
    return 5'(a % 32);
  endfunction

  // Reference: a write frame writes each full data byte; a read frame fetches once per full byte clocked (cmd included)
  task automatic build_expect(input int nd);
    ev_t e;
    int n;
    exp_q.delete();
    n = tx[0][7] ? nd : nd + 1;
    for (int k = 0; k < n; k++) begin
      e.wr   = tx[0][7];
      e.addr = acc_addr(tx[0], k);
      e.data = tx[0][7] ? tx[k+1] : mem[e.addr];
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_frame(input string tag, input int nd);
    build_expect(nd);
    check({tag, ".nstrobe"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      check($sformatf("%s.ev%0d", tag, k), 32'({got[k].wr, got[k].addr, got[k].data}),
            32'({exp_q[k].wr, exp_q[k].addr, exp_q[k].data}));
    if (!tx[0][7]) begin
      check({tag, ".miso0"}, 32'(rx[0]), 32'h0);
      for (int k = 1; k <= nd; k++)
        check($sformatf("%s.miso%0d", tag, k), 32'(rx[k]), 32'(mem[acc_addr(tx[0], k-1)]));
    end
    check({tag, ".idle"}, 32'({chip_select, spi_miso_oe}), 32'h0);
    check({tag, ".both"}, 32'(both), 32'h0);
  endtask

  initial begin
    int nw, nr;
    logic m;

    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 17 + 3);

    // Directed table: {bytes, full data bytes, extra bits, writes, reads, first address}
    vecs[0] = '{b: {8'h00, 8'h00, 8'h00, 8'h5A, 8'h84}, nd: 1, xbits: 0, exp_wr: 1, exp_rd: 0, exp_a0: 5'h04};
    vecs[1] = '{b: {8'h00, 8'h00, 8'h00, 8'hFF, 8'h00}, nd: 1, xbits: 0, exp_wr: 0, exp_rd: 2, exp_a0: 5'h00};
    vecs[2] = '{b: {8'h00, 8'h33, 8'h22, 8'h11, 8'h95}, nd: 3, xbits: 0, exp_wr: 3, exp_rd: 0, exp_a0: 5'h15};
    vecs[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h4C}, nd: 4, xbits: 0, exp_wr: 0, exp_rd: 5, exp_a0: 5'h0C};
    vecs[4] = '{b: {8'h00, 8'h00, 8'h00, 8'hA5, 8'h84}, nd: 0, xbits: 4, exp_wr: 0, exp_rd: 0, exp_a0: 5'h00};
    vecs[5] = '{b: {8'h00, 8'h00, 8'h00, 8'h3C, 8'h83}, nd: 1, xbits: 0, exp_wr: 1, exp_rd: 0, exp_a0: 5'h03};
    vecs[6] = '{b: {8'h00, 8'h00, 8'hC3, 8'h00, 8'h07}, nd: 1, xbits: 3, exp_wr: 0, exp_rd: 2, exp_a0: 5'h07};
    mem[0] = 8'h0F;

    #1;
    check("reset_out", 32'({spi_miso, spi_miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 5; i++) tx[i] = vecs[v].b[i];
      spi_frame($sformatf("vec%0d", v), vecs[v].nd + 1, vecs[v].xbits);
      nw = 0;
      nr = 0;
      foreach (got[k]) if (got[k].wr) nw++; else nr++;
      check($sformatf("vec%0d.nwr", v), 32'(nw), 32'(vecs[v].exp_wr));
      check($sformatf("vec%0d.nrd", v), 32'(nr), 32'(vecs[v].exp_rd));
      if (got.size() > 0 && (vecs[v].exp_wr + vecs[v].exp_rd) > 0)
        check($sformatf("vec%0d.a0", v), 32'(got[0].addr), 32'(vecs[v].exp_a0));
      compare_frame($sformatf("vec%0d", v), vecs[v].nd);
    end

    // Reset asserted in the middle of a read data byte
    mem[1] = 8'hFF;
    tx[0] = 8'h01;
    got.delete();
    spi_nss = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    for (int b = 7; b >= 0; b--) spi_bit(tx[0][b], m);
    for (int b = 0; b < 3; b++) spi_bit(1'b0, m);
    check("rst.pre_miso", 32'(spi_miso), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst.outputs", 32'({spi_miso, spi_miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    got.delete();
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rst.no_resume", 32'({chip_select, spi_miso_oe}), 32'h0);
    check("rst.no_strobe", 32'(got.size()), 32'h0);
    spi_nss = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    tx[0] = 8'h02;
    tx[1] = 8'h00;
    tx[2] = 8'h00;
    spi_frame("post_rst", 3, 0);
    compare_frame("post_rst", 2);

    // Random frames against the reference
    for (int it = 0; it < 20; it++) begin
      int nd, xb;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
      nd = int'($urandom_range(0, 4));
      xb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
      spi_frame($sformatf("rnd%0d", it), nd + 1, xb);
      compare_frame($sformatf("rnd%0d", it), nd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
